// File: rtl/rst_seq.sv
// rst_seq: system reset sequencer; gathers watchdog, button and software
// restart requests, stretches them into sys_rst, then blanks new triggers
// for a number of ticks. A cause/count register survives sys_rst.
//
// Ports:
//   clk        system clock
//   rst        power-on reset, asynchronous, active-high
//   tick       one-cycle pulse, nominally 1 ms
//   wdog_trig  watchdog trigger, synchronous level
//   ext_trig   external reset button, asynchronous, active-high
//   stb/we     bus strobe / write enable, data_in write data
//   data_out   read data {16'b0, count, 4'b0, cause}
//   ack        bus acknowledge (= stb)
//   sys_rst    stretched system reset, active-high
//   cause      cause register: [0] power-on [1] watchdog [2] external [3] software
//
// Optional feature: define RST_SEQ_DEBOUNCE_EN to debounce ext_trig on tick
// (DEBOUNCE_TICKS consecutive high samples); otherwise the synchronized
// rising edge is used directly.
module rst_seq #(
    parameter int HOLD_CYCLES    = 16,
    parameter int BLANK_TICKS    = 8,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        wdog_trig,
    input  logic        ext_trig,
    input  logic        stb,
    input  logic        we,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    output logic        sys_rst,
    output logic [3:0]  cause
);
    if (HOLD_CYCLES < 1 || BLANK_TICKS < 1 || DEBOUNCE_TICKS < 1) begin : g_bad_param
        $error("rst_seq: HOLD_CYCLES, BLANK_TICKS and DEBOUNCE_TICKS must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, HOLD, BLANK} state_t;

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int BW = $clog2(BLANK_TICKS + 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_TICKS - 1);

    state_t        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [BW-1:0] blank_q, blank_d;
    logic [3:0]    cause_q, cause_d;
    logic [7:0]    count_q, count_d;
    logic [1:0]    sync_q;
    logic          ext_edge, wr, sw_req, clr, trig;
    logic [3:0]    cause_base;
    logic [7:0]    count_base;
    logic          unused_data;

    assign unused_data = ^data_in[31:2];

    // Writes during blanking are acknowledged but have no effect.
    assign wr     = stb & we & (state_q != BLANK);
    assign sw_req = wr & data_in[0];
    assign clr    = wr & data_in[1];
    assign trig   = wdog_trig | ext_edge | sw_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[0], ext_trig};
    end

`ifdef RST_SEQ_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [DW-1:0] DEB_FULL = DW'(DEBOUNCE_TICKS);
    logic [DW-1:0] db_q, db_d;
    // Fires on the tick that completes the run; the counter then parks at
    // DEB_FULL so a held button cannot fire again until a low sample.
    assign ext_edge = tick & sync_q[1] & (db_q == DEB_LAST);
    always_comb begin
        db_d = !tick ? db_q : !sync_q[1] ? '0 : (db_q == DEB_FULL) ? db_q : db_q + DW'(1);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) db_q <= '0;
        else     db_q <= db_d;
    end
`else
    logic prev_q;
    assign ext_edge = sync_q[1] & ~prev_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev_q <= 1'b0;
        else     prev_q <= sync_q[1];
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HOLD;
            hold_q  <= '0;
            blank_q <= '0;
            cause_q <= 4'b0001;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            blank_q <= blank_d;
            cause_q <= cause_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = trig ? HOLD : IDLE;
            HOLD:    state_d = (hold_q == HOLD_LAST) ? BLANK : HOLD;
            BLANK:   state_d = (tick && blank_q == BLANK_LAST) ? IDLE : BLANK;
            default: state_d = IDLE;
        endcase
    end

    // Counters restart from zero whenever their state is (re)entered.
    // A clear in the same write as a software request lands first, so the
    // request is then recorded on top of the cleared register.
    always_comb begin
        hold_d     = (state_q == HOLD && state_d == HOLD) ? hold_q + HW'(1) : '0;
        blank_d    = (state_q == BLANK && state_d == BLANK) ? blank_q + BW'(tick) : '0;
        cause_base = clr ? 4'b0 : cause_q;
        count_base = clr ? 8'b0 : count_q;
        cause_d    = (state_q == IDLE && trig) ? cause_base | {sw_req, ext_edge, wdog_trig, 1'b0} : cause_base;
        count_d    = (state_q == IDLE && trig && count_base != 8'hff) ? count_base + 8'd1 : count_base;
    end

    always_comb begin
        sys_rst  = (state_q == HOLD);
        ack      = stb;
        cause    = cause_q;
        data_out = (stb && !we) ? {16'b0, count_q, 4'b0, cause_q} : 32'b0;
    end
endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: self-checking bench for rst_seq (table vectors, directed corner sequences, random vs model)
module tb_rst_seq;
    localparam int HOLD = 16;
    localparam int BLANK = 8;
    localparam int DEB = 4;
    localparam int M_IDLE = 0, M_HOLD = 1, M_BLANK = 2;

    logic        clk = 1'b0, rst = 1'b1, tick = 1'b0, wdog_trig = 1'b0, ext_trig = 1'b0;
    logic        stb = 1'b0, we = 1'b0;
    logic [31:0] data_in = '0, data_out;
    logic        ack, sys_rst;
    logic [3:0]  cause;

    always #5 clk = ~clk;

    rst_seq dut (
        .clk(clk), .rst(rst), .tick(tick), .wdog_trig(wdog_trig), .ext_trig(ext_trig),
        .stb(stb), .we(we), .data_in(data_in), .data_out(data_out), .ack(ack),
        .sys_rst(sys_rst), .cause(cause)
    );

    int checks = 0, errors = 0;
    int rises = 0;
    logic prev_sr = 1'b0, last_sr;
    logic [31:0] last_do;

    // Reference model: phase plus "cycles/ticks remaining" countdowns
    int m_mode, m_hold, m_blank, m_count, m_db;
    logic [3:0] m_cause;
    logic [2:0] m_ext;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_mode = M_HOLD; m_hold = HOLD; m_blank = 0;
        m_cause = 4'b0001; m_count = 0; m_ext = '0; m_db = 0;
    endfunction

    function automatic void m_step();
        logic wr, sw, clr, edg;
        if (rst) begin m_reset(); return; end
        wr  = stb && we && m_mode != M_BLANK;
        sw  = wr && data_in[0];
        clr = wr && data_in[1];
`ifdef RST_SEQ_DEBOUNCE_EN
        edg = tick && m_ext[1] && m_db == DEB - 1;
        if (tick) m_db = m_ext[1] ? (m_db < DEB ? m_db + 1 : DEB) : 0;
`else
        edg = m_ext[1] && !m_ext[2];
`endif
        if (clr) begin m_cause = 4'b0; m_count = 0; end
        if (m_mode == M_IDLE) begin
            if (wdog_trig || edg || sw) begin
                m_cause = m_cause | {sw, edg, wdog_trig, 1'b0};
                m_count = m_count < 255 ? m_count + 1 : 255;
                m_mode = M_HOLD; m_hold = HOLD;
            end
        end else if (m_mode == M_HOLD) begin
            m_hold--;
            if (m_hold == 0) begin m_mode = M_BLANK; m_blank = BLANK; end
        end else if (tick) begin
            m_blank--;
            if (m_blank == 0) m_mode = M_IDLE;
        end
        m_ext = {m_ext[1:0], ext_trig};
    endfunction

    function automatic logic [31:0] m_read();
        logic [7:0] c8;
        c8 = 8'(m_count);
        return (stb && !we) ? {16'b0, c8, 4'b0, m_cause} : 32'b0;
    endfunction

    // One clock: drive after the edge, check at negedge, advance model.
    task automatic cyc(input logic s, input logic w, input logic [31:0] d,
                       input logic wd, input logic tk, input logic ex);
        stb = s; we = w; data_in = d; wdog_trig = wd; tick = tk; ext_trig = ex;
        if (rst) m_reset();
        @(negedge clk);
        last_sr = sys_rst; last_do = data_out;
        if (sys_rst && !prev_sr) rises++;
        prev_sr = sys_rst;
        check("sys_rst", {31'b0, sys_rst}, {31'b0, m_mode == M_HOLD});
        check("data_out", data_out, m_read());
        check("cause", {28'b0, cause}, {28'b0, m_cause});
        check("ack", {31'b0, ack}, {31'b0, s});
        m_step();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n, input logic tk);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'b0, 1'b0, tk, 1'b0);
    endtask

    // From the first HOLD cycle: remaining hold, then a full blank with ticks.
    task automatic finish_seq();
        idle(HOLD, 1'b0);
        idle(BLANK, 1'b1);
    endtask

    task automatic rd();
        cyc(1'b1, 1'b0, 32'b0, 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        int n; logic s; logic w; logic [31:0] d; logic wd; logic tk;
        logic exp_rst; logic [31:0] exp_do;
    } vec_t;
    vec_t tbl[10];

    initial begin
        int r0, c0, hi;
        logic ex;
        tbl[0] = '{HOLD, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h0};
        tbl[1] = '{1,    1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'h1};
        tbl[2] = '{BLANK,1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[3] = '{1,    1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[4] = '{HOLD, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h0};
        tbl[5] = '{1,    1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'h103};
        tbl[6] = '{BLANK,1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[7] = '{1,    1'b1, 1'b1, 32'd3, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[8] = '{HOLD, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h0};
        tbl[9] = '{1,    1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'h108};

        m_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd();
            check("por_sys_rst", {31'b0, last_sr}, 32'd1);
            check("por_read", last_do, 32'h1);
        end
        rst = 1'b0;

        foreach (tbl[k]) begin
            for (int j = 0; j < tbl[k].n; j++) begin
                cyc(tbl[k].s, tbl[k].w, tbl[k].d, tbl[k].wd, tbl[k].tk, 1'b0);
                check($sformatf("tbl%0d_sys_rst", k), {31'b0, last_sr}, {31'b0, tbl[k].exp_rst});
                check($sformatf("tbl%0d_dout", k), last_do, tbl[k].exp_do);
            end
        end
        idle(BLANK, 1'b1);

        // Watchdog held through hold and blank: one sequence, then another on IDLE entry
        c0 = m_count; r0 = rises;
        for (int i = 0; i < 1 + HOLD + BLANK; i++) cyc(1'b0, 1'b0, 32'b0, 1'b1, 1'b1, 1'b0);
        check("blank_one_seq", rises - r0, 1);
        cyc(1'b0, 1'b0, 32'b0, 1'b1, 1'b1, 1'b0);
        finish_seq();
        check("blank_two_seq", rises - r0, 2);
        rd();
        check("blank_count", {24'b0, last_do[15:8]}, c0 + 2);

        // Clear, then simultaneous software write and watchdog
        cyc(1'b1, 1'b1, 32'd2, 1'b0, 1'b0, 1'b0);
        rd();
        check("clear_read", last_do, 32'h0);
        r0 = rises;
        cyc(1'b1, 1'b1, 32'd1, 1'b1, 1'b0, 1'b0);
        finish_seq();
        check("simul_one_seq", rises - r0, 1);
        rd();
        check("simul_read", last_do, 32'h10A);
        cyc(1'b1, 1'b1, 32'd2, 1'b0, 1'b0, 1'b0);
        rd();
        check("clear2_read", last_do, 32'h0);

`ifndef RST_SEQ_DEBOUNCE_EN
        // 3-cycle button pulse: sys_rst rises 3 cycles after the edge
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 32'b0, 1'b0, 1'b0, i < 3);
            check($sformatf("ext_lat%0d", i), {31'b0, last_sr}, {31'b0, i == 3});
        end
        idle(HOLD - 1, 1'b0);
        idle(BLANK, 1'b1);
        rd();
        check("ext_read", last_do, 32'h104);
`else
        r0 = rises;
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 32'b0, 1'b0, 1'b1, i < 3);
        check("deb_short", rises - r0, 0);
        for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0, 32'b0, 1'b0, 1'b1, i < 5);
        check("deb_long", rises - r0, 1);
        rd();
        check("deb_cause", {28'b0, last_do[3:0]}, 32'h4);
`endif

        // rst in the middle of a hold restarts a full hold and overwrites cause
        cyc(1'b0, 1'b0, 32'b0, 1'b1, 1'b0, 1'b0);
        idle(5, 1'b0);
        rst = 1'b1;
        idle(1, 1'b0);
        rst = 1'b0;
        hi = 0;
        for (int i = 0; i < HOLD + 4; i++) begin
            idle(1, 1'b0);
            hi += int'(last_sr);
        end
        check("midrst_hold", hi, HOLD);
        rd();
        check("midrst_read", last_do, 32'h1);
        idle(BLANK, 1'b1);

        // Count saturation
        for (int i = 0; i < 260; i++) begin
            cyc(1'b1, 1'b1, 32'd1, 1'b0, 1'b0, 1'b0);
            finish_seq();
        end
        rd();
        check("sat_read", last_do, 32'h0000FF09);

        // Random traffic against the model
        ex = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) ex = ~ex;
            rst = ($urandom_range(0, 499) == 0);
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                ($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'd0,
                $urandom_range(0, 31) == 0, $urandom_range(0, 3) == 0, ex);
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
